seq_sorter: RTL and testbench
=============================

SEQ_SORTER -- requirements
Module: seq_sorter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each element; legal range >= 1.
REQ-002 SHALL have parameter DEPTH, default 6: number of elements sorted per job; legal range >= 2.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1: job request; sampled on every rising edge.
REQ-006 SHALL have port desc  input  1: ordering mode (0 = ascending, 1 = descending); sampled only with an accepted start.
REQ-007 SHALL have port din  input  WIDTH*DEPTH: unsigned elements; element i is din[i*WIDTH +: WIDTH].
REQ-008 SHALL have port busy  output  1: high while a job is sorting.
REQ-009 SHALL have port done  output  1: single-cycle pulse marking dout valid.
REQ-010 SHALL have port dout  output  WIDTH*DEPTH: sorted elements; element i is dout[i*WIDTH +: WIDTH].

Function
REQ-011 SHALL implement FSM states IDLE, SORT, DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: din loaded into the element registers, desc latched, pass counter cleared, next state SORT.
REQ-013 In DONE with start=0, the next state SHALL be IDLE; done SHALL be high only in DONE.
REQ-014 In SORT, start SHALL be ignored; din and desc changes SHALL have no effect on the job.
REQ-015 SORT SHALL execute exactly DEPTH odd-even transposition passes, one pass per cycle, pass counter 0..DEPTH-1.
REQ-016 An even pass SHALL compare-swap pairs (0,1),(2,3),...; an odd pass SHALL compare-swap pairs (1,2),(3,4),...
REQ-017 An element with no partner in a pass (odd DEPTH, or the end positions on odd passes) SHALL be held unchanged.
REQ-018 Ascending mode SHALL swap a pair (j,j+1) only when elem[j] > elem[j+1]; descending mode only when elem[j] < elem[j+1].
REQ-019 Equal elements SHALL never be swapped.
REQ-020 Comparisons SHALL be unsigned, full WIDTH; no truncation or extension.
REQ-021 After pass DEPTH-1 the FSM SHALL go to DONE.
REQ-022 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+DEPTH, i.e. DEPTH+1 cycles after the accepting edge.
REQ-023 busy SHALL be high exactly in SORT (DEPTH cycles per job).
REQ-024 dout SHALL drive the element registers directly; it is valid when done=1 and SHALL hold its value through IDLE until the next accepted start.
REQ-025 dout contents during SORT are intermediate and SHALL NOT be relied on.
REQ-026 start=1 in DONE SHALL begin a new job on that edge with no idle cycle (back-to-back throughput of one job per DEPTH+1 cycles).
REQ-027 The pass counter SHALL be $clog2(DEPTH) bits wide, minimum 1 bit.

Reset
REQ-028 On a rising edge with rst_n=0, the FSM SHALL enter IDLE, the pass counter and latched desc SHALL clear, all element registers SHALL become 0, and busy=0, done=0, dout=0.
REQ-029 Reset SHALL take priority over start, including during SORT; the aborted job SHALL produce no done pulse.
REQ-030 start sampled on the first edge with rst_n=1 SHALL be accepted normally.

Verification (WIDTH=8, DEPTH=6, din listed as element 0..5)
REQ-031 Ascending: din=5,3,9,1,7,2, desc=0, start pulse -> busy for 6 cycles, done on the 7th cycle, dout=1,2,3,5,7,9.
REQ-032 Descending: same din, desc=1 -> dout=9,7,5,3,2,1; also check worst case din=255,200,100,50,10,0 with desc=0 -> dout=0,10,50,100,200,255.
REQ-033 Duplicates: din=4,4,0,4,255,0, desc=0 -> dout=0,0,4,4,4,255.
REQ-034 Busy protection: start with din=6,5,4,3,2,1; then mid-SORT pulse start with din=all 0xAA and desc=1 -> result 1,2,3,4,5,6; exactly one done pulse.
REQ-035 Reset mid-job: rst_n=0 for one edge during pass 3 -> busy=0, done=0, dout=0 next cycle, and no done pulse thereafter.
REQ-036 Back-to-back: start held high in DONE with new din=10,20,30,40,50,60, desc=1 -> next done exactly 7 cycles later with dout=60,50,40,30,20,10.

Source files
------------

// File: rtl/seq_sorter.sv
// rtl/seq_sorter.sv - odd-even transposition sorter, one pass per cycle, DEPTH passes per job
module seq_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   desc,
    input  logic [WIDTH*DEPTH-1:0] din,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*DEPTH-1:0] dout
);

    localparam int CW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_PASS = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    pass_cnt;
    logic             desc_q;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] elem    [DEPTH];
    logic [WIDTH-1:0] elem_nx [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                step = 1'b1;
                if (pass_cnt == LAST_PASS) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = SORT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pairs are disjoint within a pass, so every swap reads the pre-pass values.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            elem_nx[j] = elem[j];
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            if ((j % 2) == int'(pass_cnt[0])) begin
                if (desc_q ? (elem[j] < elem[j+1]) : (elem[j] > elem[j+1])) begin
                    elem_nx[j]   = elem[j+1];
                    elem_nx[j+1] = elem[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            desc_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                elem[i] <= '0;
            end
        end else if (load) begin
            pass_cnt <= '0;
            desc_q   <= desc;
            for (int i = 0; i < DEPTH; i++) begin
                elem[i] <= din[i*WIDTH +: WIDTH];
            end
        end else if (step) begin
            pass_cnt <= pass_cnt + CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                elem[i] <= elem_nx[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_dout
        assign dout[g*WIDTH +: WIDTH] = elem[g];
    end

endmodule

// File: tb/tb_seq_sorter.sv
// tb/tb_seq_sorter.sv - self-checking bench for seq_sorter
module tb_seq_sorter;

    localparam int W = 8;
    localparam int D = 6;
    localparam int N = W * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         desc = 1'b0;
    logic [N-1:0] din = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    seq_sorter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .desc  (desc),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] din;
        logic         desc;
        logic [N-1:0] exp;
    } vec_t;

    function automatic logic [N-1:0] pk(input int e0, input int e1, input int e2,
                                        input int e3, input int e4, input int e5);
        logic [N-1:0] v;
        v = {e5[W-1:0], e4[W-1:0], e3[W-1:0], e2[W-1:0], e1[W-1:0], e0[W-1:0]};
        return v;
    endfunction

    // Reference: plain selection sort of the element values.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic dsc);
        int a [D];
        int t;
        logic [N-1:0] r;
        for (int i = 0; i < D; i++) a[i] = int'(d[i*W +: W]);
        for (int i = 0; i < D; i++) begin
            for (int k = i + 1; k < D; k++) begin
                if (dsc ? (a[k] > a[i]) : (a[k] < a[i])) begin
                    t = a[i]; a[i] = a[k]; a[k] = t;
                end
            end
        end
        for (int i = 0; i < D; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called just after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 20);
    endtask

    task automatic launch(input logic [N-1:0] d, input logic dsc);
        din   = d;
        desc  = dsc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    vec_t vecs [5];
    int lat, bcnt, npulse;
    logic [N-1:0] d, held;
    logic dsc;

    initial begin
        vecs[0] = '{pk(5,3,9,1,7,2),         1'b0, pk(1,2,3,5,7,9)};
        vecs[1] = '{pk(5,3,9,1,7,2),         1'b1, pk(9,7,5,3,2,1)};
        vecs[2] = '{pk(255,200,100,50,10,0), 1'b0, pk(0,10,50,100,200,255)};
        vecs[3] = '{pk(4,4,0,4,255,0),       1'b0, pk(0,0,4,4,4,255)};
        vecs[4] = '{pk(6,5,4,3,2,1),         1'b0, pk(1,2,3,4,5,6)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dout", 64'(dout), 64'd0);

        // Release reset and request the first job on the same edge.
        rst_n = 1'b1;
        for (int v = 0; v < 5; v++) begin
            launch(vecs[v].din, vecs[v].desc);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(D + 1));
            check($sformatf("vec%0d_busy", v), 64'(bcnt), 64'(D));
            check($sformatf("vec%0d_dout", v), 64'(dout), 64'(vecs[v].exp));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", v), 64'(done), 64'd0);
            check($sformatf("vec%0d_hold", v), 64'(dout), 64'(vecs[v].exp));
        end

        // Start, din and desc during SORT must not disturb the job.
        launch(pk(6,5,4,3,2,1), 1'b0);
        repeat (2) @(negedge clk);
        din = {D{8'hAA}}; desc = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        held = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) begin npulse++; held = dout; end
        end
        check("busy_prot_pulses", 64'(npulse), 64'd1);
        check("busy_prot_dout", 64'(held), 64'(pk(1,2,3,4,5,6)));

        // Reset while pass 3 is pending.
        launch(pk(9,8,7,6,5,4), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dout", 64'(dout), 64'd0);
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("midrst_no_done", 64'(npulse), 64'd0);

        // Back-to-back: start held in DONE.
        launch(pk(3,1,2,6,5,4), 1'b0);
        wait_done(lat, bcnt);
        check("b2b_first_dout", 64'(dout), 64'(pk(1,2,3,4,5,6)));
        launch(pk(10,20,30,40,50,60), 1'b1);
        wait_done(lat, bcnt);
        check("b2b_latency", 64'(lat), 64'(D + 1));
        check("b2b_dout", 64'(dout), 64'(pk(60,50,40,30,20,10)));

        // Randomized jobs, with din/desc scrambled while sorting.
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            for (int i = 0; i < D; i++) begin
                d[i*W +: W] = (r % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            end
            dsc = 1'($urandom);
            launch(d, dsc);
            din  = {$urandom, $urandom};
            desc = ~dsc;
            wait_done(lat, bcnt);
            check($sformatf("rand%0d_latency", r), 64'(lat), 64'(D + 1));
            check($sformatf("rand%0d_dout", r), 64'(dout), 64'(model(d, dsc)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
